// File: rtl/aes_wb_frontend.sv
//------------------------------------------------------------------------------
// aes_wb_frontend
//
// Wishbone slave register front-end for the AES round core. Firmware loads a
// 128-bit key and a 128-bit data block, starts one encryption, and reads back
// the 128-bit result. The block sequences the core with a start/done
// handshake, reports status, and raises a level interrupt on completion.
//
// Register map (byte offsets from BASE_ADDR, word offset = adr[7:2]):
//   0x00-0x0C  KEY0-3   RW, byte lanes honoured, KEY3 drives core_key[127:96]
//   0x10-0x1C  DIN0-3   RW, byte lanes honoured, DIN3 drives core_din[127:96]
//   0x20       CTRL     bit0 START (write-1, reads 0), bit1 IRQ_EN (RW)
//   0x24       STATUS   bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C)
//   0x30-0x3C  DOUT0-3  RO, captured from core_dout on core_done
//   others     read 0, writes acked and ignored
//
// Ports:
//   wb_clk_i, wb_rst_i      clock and synchronous active-high reset
//   wbs_stb_i, wbs_cyc_i    Wishbone strobe / cycle
//   wbs_we_i, wbs_sel_i     write enable and byte lane selects
//   wbs_adr_i, wbs_dat_i    byte address and write data
//   wbs_ack_o, wbs_dat_o    registered acknowledge and read data
//   core_key, core_din      key and plaintext presented to the core
//   core_start              one-cycle start pulse to the core
//   core_done, core_dout    one-cycle completion pulse and result from core
//   irq                     completion interrupt (DONE & IRQ_EN, registered)
//------------------------------------------------------------------------------
module aes_wb_frontend #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned CORE_TIMEOUT = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic         irq
);

    // The watchdog counter is 8 bits wide, so the limit is truncated to fit.
    localparam logic [7:0] TIMEOUT_LIMIT = CORE_TIMEOUT[7:0];

    localparam logic [5:0] OFF_CTRL   = 6'h08;
    localparam logic [5:0] OFF_STATUS = 6'h09;

    localparam logic [3:0] GRP_KEY  = 4'h0;
    localparam logic [3:0] GRP_DIN  = 4'h1;
    localparam logic [3:0] GRP_DOUT = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    timeoutCnt_q, timeoutCnt_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  din_q, din_d;
    logic [127:0]  dout_q, dout_d;
    logic          irqEn_q, irqEn_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          startPend_q, startPend_d;
    logic          ack_q, ack_d;
    logic          irq_q, irq_d;
    logic [31:0]   rdData_q, rdData_d;

    logic          hit;
    logic          access;
    logic          wrAccess;
    logic          rdAccess;
    logic          busy;
    logic [5:0]    wordOff;
    logic [6:0]    wordBase;
    logic          keySel;
    logic          dinSel;
    logic          doutSel;
    logic          ctrlSel;
    logic          statusSel;
    logic          coreDoneSet;
    logic          timeoutErr;
    logic          busyViolation;
    logic          doneClr;
    logic          errClr;
    logic [31:0]   rdValue;
    logic          unusedAdrBits;

    // Merge a 32-bit write into an existing word, one byte lane at a time.
    function automatic logic [31:0] laneMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  laneSel);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = laneSel[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
        end
        return merged;
    endfunction

    // The byte offset within a word carries no meaning for this slave.
    assign unusedAdrBits = ^wbs_adr_i[1:0];

    // Address decode. An access is a hit while ack is low, so a held strobe
    // is served every other cycle and each transfer acts exactly once.
    always_comb begin
        hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        access    = hit & ~ack_q;
        wrAccess  = access & wbs_we_i;
        rdAccess  = access & ~wbs_we_i;
        wordOff   = wbs_adr_i[7:2];
        wordBase  = {wordOff[1:0], 5'd0};
        keySel    = (wordOff[5:2] == GRP_KEY);
        dinSel    = (wordOff[5:2] == GRP_DIN);
        doutSel   = (wordOff[5:2] == GRP_DOUT);
        ctrlSel   = (wordOff == OFF_CTRL);
        statusSel = (wordOff == OFF_STATUS);
        busy      = (state_q != ST_IDLE);
    end

    // Core sequencing FSM. A completion wins over a timeout on the same
    // cycle; core_done is only honoured while waiting for it.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        coreDoneSet  = 1'b0;
        timeoutErr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startPend_q) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                timeoutCnt_d = 8'd0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    coreDoneSet = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timeoutCnt_q == TIMEOUT_LIMIT) begin
                    timeoutErr = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register writes. KEY, DIN and START are locked while the core is busy:
    // such writes are still acked but only flag ERR. A START accepted in IDLE
    // is held for one cycle so core_start follows the ack cycle.
    always_comb begin
        key_d         = key_q;
        din_d         = din_q;
        irqEn_d       = irqEn_q;
        startPend_d   = 1'b0;
        busyViolation = 1'b0;
        doneClr       = 1'b0;
        errClr        = 1'b0;
        if (wrAccess) begin
            if (keySel) begin
                if (busy) begin
                    busyViolation = 1'b1;
                end else begin
                    key_d[wordBase +: 32] = laneMerge(key_q[wordBase +: 32], wbs_dat_i, wbs_sel_i);
                end
            end
            if (dinSel) begin
                if (busy) begin
                    busyViolation = 1'b1;
                end else begin
                    din_d[wordBase +: 32] = laneMerge(din_q[wordBase +: 32], wbs_dat_i, wbs_sel_i);
                end
            end
            if (ctrlSel && wbs_sel_i[0]) begin
                irqEn_d = wbs_dat_i[1];
                if (wbs_dat_i[0]) begin
                    if (busy) begin
                        busyViolation = 1'b1;
                    end else begin
                        startPend_d = 1'b1;
                    end
                end
            end
            if (statusSel && wbs_sel_i[0]) begin
                doneClr = wbs_dat_i[1];
                errClr  = wbs_dat_i[2];
            end
        end
    end

    // Sticky status bits: a set on the same edge as a clear leaves the bit set.
    always_comb begin
        done_d = (done_q & ~doneClr) | coreDoneSet;
        err_d  = (err_q & ~errClr) | busyViolation | timeoutErr;
        dout_d = coreDoneSet ? core_dout : dout_q;
        irq_d  = done_q & irqEn_q;
    end

    // Read mux. Values reflect register state before any write on this edge.
    always_comb begin
        rdValue = 32'd0;
        if (keySel) begin
            rdValue = key_q[wordBase +: 32];
        end else if (dinSel) begin
            rdValue = din_q[wordBase +: 32];
        end else if (doutSel) begin
            rdValue = dout_q[wordBase +: 32];
        end else if (ctrlSel) begin
            rdValue = {30'd0, irqEn_q, 1'b0};
        end else if (statusSel) begin
            rdValue = {29'd0, err_q, done_q, busy};
        end
        ack_d    = access;
        rdData_d = rdAccess ? rdValue : 32'd0;
    end

    // State register for the whole block, cleared synchronously.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            timeoutCnt_q <= 8'd0;
            key_q        <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            irqEn_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            startPend_q  <= 1'b0;
            ack_q        <= 1'b0;
            irq_q        <= 1'b0;
            rdData_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            key_q        <= key_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
            irqEn_q      <= irqEn_d;
            done_q       <= done_d;
            err_q        <= err_d;
            startPend_q  <= startPend_d;
            ack_q        <= ack_d;
            irq_q        <= irq_d;
            rdData_q     <= rdData_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdData_q;
    assign core_key   = key_q;
    assign core_din   = din_q;
    assign core_start = (state_q == ST_FIRE);
    assign irq        = irq_q;

endmodule

// File: tb/tb_aes_wb_frontend.sv
//------------------------------------------------------------------------------
// tb_aes_wb_frontend
//
// Directed bench for aes_wb_frontend. Expected read data is queued when a
// read is issued and compared when the slave acks it. A small core model
// answers each core_start after a fixed delay (or never, when disabled).
//------------------------------------------------------------------------------
module tb_aes_wb_frontend;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic         wbs_stb_i = 1'b0;
    logic         wbs_cyc_i = 1'b0;
    logic         wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = 4'h0;
    logic [31:0]  wbs_adr_i = 32'd0;
    logic [31:0]  wbs_dat_i = 32'd0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_start;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    logic [31:0]  expQ[$];

    bit           coreRespond = 1'b0;
    int           pending = 0;
    int           startCount = 0;
    int           startCycle = 0;
    int           doneCycle = 0;
    logic [127:0] seenKey = '0;
    logic [127:0] seenDin = '0;

    logic [127:0] coreResult = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] keyVal     = 128'h0c0d0e0f_08090a0b_04050607_00010203;
    logic [127:0] dinVal     = 128'hccddeeff_8899aabb_44556677_00112233;

    aes_wb_frontend #(
        .BASE_ADDR    (BASE),
        .CORE_TIMEOUT (20)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_start (core_start),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .irq        (irq)
    );

    // Free-running 100 MHz clock.
    always #5 wb_clk_i = ~wb_clk_i;

    // Cycle index, advanced on every rising edge.
    always @(posedge wb_clk_i) begin
        cycleCount = cycleCount + 1;
    end

    // Core model: latches what it was started with and, when enabled,
    // returns the result as a one-cycle core_done ten cycles after start.
    always @(negedge wb_clk_i) begin
        core_done = 1'b0;
        if (core_start) begin
            startCount = startCount + 1;
            startCycle = cycleCount;
            seenKey    = core_key;
            seenDin    = core_din;
            if (coreRespond) begin
                pending = 10;
            end
        end else if (pending > 0) begin
            pending = pending - 1;
            if (pending == 0) begin
                core_done = 1'b1;
                core_dout = coreResult;
                doneCycle = cycleCount;
            end
        end
    end

    // Hard stop in case something wedges beyond every local bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One Wishbone transfer; reads queue their expected word and compare it
    // when the ack arrives. A missing ack within 8 cycles is a failure.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input logic [31:0] expRead);
        bit          gotAck;
        logic [31:0] expWord;
        gotAck = 1'b0;
        if (!we) expQ.push_back(expRead);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        for (int i = 0; i < 8 && !gotAck; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o === 1'b1) begin
                gotAck    = 1'b1;
                wbs_stb_i = 1'b0;
                wbs_cyc_i = 1'b0;
                wbs_we_i  = 1'b0;
                if (!we) begin
                    expWord = expQ.pop_front();
                    checkOutput(tag, {96'd0, wbs_dat_o}, {96'd0, expWord});
                end
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        checkOutput($sformatf("%s ack", tag), {127'd0, gotAck}, 128'd1);
        if (!gotAck && !we && expQ.size() > 0) void'(expQ.pop_front());
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic waitStart(input int prev);
        for (int i = 0; i < 6 && startCount == prev; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic waitIrq(output int seenAt);
        seenAt = -1;
        for (int i = 0; i < 40 && seenAt < 0; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (irq === 1'b1) seenAt = cycleCount;
        end
    endtask

    // Directed sequence covering reset, load/start/complete, busy lockout,
    // timeout, byte lanes, decode and reset during an operation.
    initial begin
        int prev;
        int ackCycle;
        int irqCycle;
        int s;
        int ackCount;
        bit sawAck;

        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;

        checkOutput("reset ack", {127'd0, wbs_ack_o}, 128'd0);
        checkOutput("reset dat", {96'd0, wbs_dat_o}, 128'd0);
        checkOutput("reset irq", {127'd0, irq}, 128'd0);
        checkOutput("reset core_start", {127'd0, core_start}, 128'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("reset read 0x%02h", i * 4), 1'b0, BASE + 32'(i * 4),
                          32'd0, 4'hF, 32'd0);
        end

        applyStimulus("key1 lane1 write", 1'b1, BASE + 32'h04, 32'hAABBCCDD, 4'b0010, 32'd0);
        applyStimulus("key1 lane1 read", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'h0000CC00);

        sawAck    = 1'b0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE + 32'h104;
        wbs_dat_i = 32'hFFFFFFFF;
        wbs_sel_i = 4'hF;
        repeat (4) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o !== 1'b0) sawAck = 1'b1;
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        checkOutput("foreign addr ack", {127'd0, sawAck}, 128'd0);
        applyStimulus("key1 after foreign", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'h0000CC00);

        ackCount  = 0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_adr_i = BASE + 32'h04;
        repeat (6) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o === 1'b1) ackCount++;
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        checkOutput("held strobe acks", 128'(ackCount), 128'd3);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("key%0d write", i), 1'b1, BASE + 32'(i * 4),
                          keyVal[32*i +: 32], 4'hF, 32'd0);
            applyStimulus($sformatf("din%0d write", i), 1'b1, BASE + 32'h10 + 32'(i * 4),
                          dinVal[32*i +: 32], 4'hF, 32'd0);
        end
        applyStimulus("ctrl irq_en write", 1'b1, BASE + 32'h20, 32'h2, 4'h1, 32'd0);
        applyStimulus("ctrl read", 1'b0, BASE + 32'h20, 32'd0, 4'hF, 32'h2);

        coreRespond = 1'b1;
        prev = startCount;
        applyStimulus("start write", 1'b1, BASE + 32'h20, 32'h3, 4'h1, 32'd0);
        ackCycle = cycleCount;
        waitStart(prev);
        checkOutput("start pulses", 128'(startCount - prev), 128'd1);
        checkOutput("start latency", 128'(startCycle), 128'(ackCycle + 1));
        checkOutput("core_key", seenKey, keyVal);
        checkOutput("core_din", seenDin, dinVal);
        waitIrq(irqCycle);
        checkOutput("irq lag after done", 128'(irqCycle), 128'(doneCycle + 2));
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("dout%0d read", i), 1'b0, BASE + 32'h30 + 32'(i * 4),
                          32'd0, 4'hF, coreResult[32*i +: 32]);
        end
        applyStimulus("status done", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h2);
        applyStimulus("w1c done", 1'b1, BASE + 32'h24, 32'h2, 4'h1, 32'd0);
        checkOutput("irq still high one cycle", {127'd0, irq}, 128'd1);
        @(posedge wb_clk_i);
        #1;
        checkOutput("irq cleared", {127'd0, irq}, 128'd0);
        applyStimulus("status cleared", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h0);

        prev = startCount;
        applyStimulus("start 2 write", 1'b1, BASE + 32'h20, 32'h3, 4'h1, 32'd0);
        applyStimulus("din0 busy write", 1'b1, BASE + 32'h10, 32'hdeadbeef, 4'hF, 32'd0);
        applyStimulus("start busy write", 1'b1, BASE + 32'h20, 32'h3, 4'h1, 32'd0);
        waitIrq(irqCycle);
        checkOutput("busy op irq seen", {127'd0, irq}, 128'd1);
        checkOutput("busy op start pulses", 128'(startCount - prev), 128'd1);
        applyStimulus("din0 unchanged", 1'b0, BASE + 32'h10, 32'd0, 4'hF, 32'h00112233);
        applyStimulus("status done err", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h6);
        applyStimulus("w1c done err", 1'b1, BASE + 32'h24, 32'h6, 4'h1, 32'd0);
        applyStimulus("status clear 2", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h0);

        coreRespond = 1'b0;
        prev = startCount;
        applyStimulus("start timeout", 1'b1, BASE + 32'h20, 32'h3, 4'h1, 32'd0);
        waitStart(prev);
        checkOutput("timeout start pulses", 128'(startCount - prev), 128'd1);
        s = startCycle;
        waitUntil(s + 21);
        applyStimulus("status last wait cycle", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h1);
        applyStimulus("status after timeout", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h4);
        applyStimulus("dout0 kept", 1'b0, BASE + 32'h30, 32'd0, 4'hF, coreResult[31:0]);
        applyStimulus("dout3 kept", 1'b0, BASE + 32'h3C, 32'd0, 4'hF, coreResult[127:96]);
        checkOutput("timeout irq", {127'd0, irq}, 128'd0);
        applyStimulus("w1c err", 1'b1, BASE + 32'h24, 32'h4, 4'h1, 32'd0);

        coreRespond = 1'b1;
        prev = startCount;
        applyStimulus("start reset op", 1'b1, BASE + 32'h20, 32'h3, 4'h1, 32'd0);
        waitStart(prev);
        s = startCycle;
        waitUntil(s + 7);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        waitUntil(s + 14);
        checkOutput("post reset irq", {127'd0, irq}, 128'd0);
        checkOutput("post reset start pulses", 128'(startCount - prev), 128'd1);
        applyStimulus("post reset status", 1'b0, BASE + 32'h24, 32'd0, 4'hF, 32'h0);
        applyStimulus("post reset ctrl", 1'b0, BASE + 32'h20, 32'd0, 4'hF, 32'h0);
        applyStimulus("post reset key0", 1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("post reset dout%0d", i), 1'b0, BASE + 32'h30 + 32'(i * 4),
                          32'd0, 4'hF, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_wb_frontend.md
Name: aes_wb_frontend

Overview:
Wishbone slave register front-end that sits between the Caravel user-project Wishbone bus and the AES round core. Firmware on the PicoRV32 uses it to load a 128-bit key and a 128-bit data block, start one encryption, and read the 128-bit result. It sequences the core through a start/done handshake, reports status, and raises an interrupt on completion.

Parameters:
BASE_ADDR, 32'h3000_0000, slave base; decode compares wbs_adr_i[31:8] to BASE_ADDR[31:8].
CORE_TIMEOUT, 255, max cycles in WAIT before abort with ERR; 8-bit counter.

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge.
wb_rst_i  in  1  synchronous, active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte lane select.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
core_key  out  128  key to core; KEY3 is bits [127:96].
core_din  out  128  plaintext to core; DIN3 is bits [127:96].
core_start  out  1  one-cycle start pulse.
core_done  in  1  one-cycle pulse; core_dout valid in the same cycle.
core_dout  in  128  result from core.
irq  out  1  completion interrupt, level.

Behaviour:
- One clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i; it takes effect on the rising edge where it is sampled high.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_start=0, irq=0, KEY/DIN/DOUT=0, CTRL=0, STATUS=0, FSM=IDLE, timeout counter=0.
- Address decode and offsets:
  - hit = stb & cyc & (adr[31:8]==BASE_ADDR[31:8]). No hit means no ack and no state change.
  - Word offset is adr[7:2].
  - 0x00-0x0C: KEY0-3, RW.
  - 0x10-0x1C: DIN0-3, RW.
  - 0x20: CTRL. bit0 START is write-1, always reads 0. bit1 IRQ_EN is RW.
  - 0x24: STATUS. bit0 BUSY is RO. bit1 DONE is sticky, W1C. bit2 ERR is sticky, W1C.
  - 0x30-0x3C: DOUT0-3, RO.
  - Unmapped offsets read 0; writes to them are ignored but acked.
- Ack and read data:
  - Ack is registered. On an edge with hit & !ack, ack goes 1 for exactly one cycle, then 0.
  - A held strobe therefore gets one ack every two cycles.
  - wbs_dat_o is registered on the same edge as ack and is valid while ack=1. It is 0 otherwise.
- Writes:
  - A write takes effect on the edge that raises ack.
  - Byte lanes are honoured on KEY, DIN and CTRL[1].
  - START and the W1C bits act when lane 0 is selected.
- FSM states and transitions:
  - IDLE: START write moves to FIRE. BUSY=0.
  - FIRE: core_start=1 for this single cycle; clear timeout counter; go to WAIT.
  - WAIT: on core_done, capture core_dout into DOUT, set DONE, go to IDLE.
  - WAIT: when the counter reaches CORE_TIMEOUT, set ERR, go to IDLE, and leave DOUT unchanged.
  - BUSY=1 in FIRE and WAIT.
- Latency: core_start is high in the cycle immediately after the ack of the START write.
- Busy protection: while BUSY=1, writes to KEY, DIN or START are acked but discarded, and they set ERR. CTRL[1] and the STATUS W1C bits remain writable.
- Simultaneous events:
  - A W1C of DONE on the same edge as core_done leaves DONE=1 (set wins).
  - A START write on the same edge as the WAIT→IDLE transition counts as written while busy: it sets ERR and is discarded.
  - A core_done outside WAIT is ignored.
- irq = DONE & IRQ_EN, registered, so it lags DONE/IRQ_EN by one cycle.
- Reset mid-operation: FSM returns to IDLE. No core_start follows reset. A core_done arriving after reset is ignored.

Test Plan:
- Reset, then read all registers → all 0, BUSY=0, irq=0. Read at offset 0x28 → 0.
- Write KEY0-3=000102030405060708090a0b0c0d0e0f (KEY3 holds 0x0c0d0e0f) and DIN0-3 = 00112233445566778899aabbccddeeff. Set IRQ_EN, write START.
  - Required: core_start one cycle after the ack, with correct core_key/core_din.
  - Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles → DOUT holds it, DONE=1, irq=1 one cycle later.
  - W1C DONE → irq=0.
- During WAIT, write DIN0=0xdeadbeef and write START → both acked. DIN0 unchanged, ERR=1, only one core_start seen.
- Core never responds with CORE_TIMEOUT=20 → BUSY drops after about 21 cycles in WAIT, ERR=1, DONE=0, DOUT unchanged.
- sel=4'b0010 write of 0xAABBCCDD to KEY1 (prior value 0) → KEY1 reads 0x0000CC00. Access with adr[31:8] not matching BASE → no ack.
- Assert wb_rst_i in WAIT, then pulse core_done 3 cycles later → FSM in IDLE, DONE=0, DOUT=0, irq=0.
